// File: rtl/sm_step_driver.sv
// Step/direction pulse generator for a stepper power stage: enable wake-up delay,
// direction setup, one-deep request slot, position counter. Soft limits: SM_POS_LIMIT_EN.
module sm_step_driver #(
  parameter int unsigned        PULSE_W   = 50,
  parameter int unsigned        GAP_W     = 50,
  parameter int unsigned        DIR_SETUP = 10,
  parameter int unsigned        EN_DELAY  = 500,
  parameter logic signed [15:0] POS_MIN   = -16'sd30000,
  parameter logic signed [15:0] POS_MAX   = 16'sd30000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               drv_enable_SM,
  input  logic               drv_step,
  input  logic               drv_dir,
  output logic               sm_en,
  output logic               sm_step,
  output logic               sm_dir,
  output logic               busy,
  output logic signed [15:0] position,
  output logic               step_dropped,
  output logic               limit_hit
);

  typedef enum logic [2:0] {DISABLED, WAKE, IDLE, DIR_SET, PULSE_HI, PULSE_LO} state_t;

  localparam logic [15:0] T_WAKE = 16'(EN_DELAY - 1);
  localparam logic [15:0] T_DIR  = 16'(DIR_SETUP - 1);
  localparam logic [15:0] T_HI   = 16'(PULSE_W - 1);
  localparam logic [15:0] T_LO   = 16'(GAP_W - 1);

`ifdef SM_POS_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, pos_q, pos_d;
  logic        sm_en_q, sm_en_d, sm_step_q, sm_step_d, sm_dir_q, sm_dir_d;
  logic        pend_vld_q, pend_vld_d, pend_dir_q, pend_dir_d;
  logic        dropped_q, dropped_d, limit_q, limit_d;
  logic        tmr_done, at_serve, lim_block, srv_vld, srv_dir;
  logic signed [17:0] proj, nxt;

  function automatic logic [15:0] delta(input logic d);
    return d ? 16'h0001 : 16'hffff;
  endfunction

  // Projected position once the in-flight and parked steps have executed
  always_comb begin
    proj = 18'($signed(pos_q));
    if (state_q == DIR_SET) proj = proj + (sm_dir_q ? 18'sd1 : -18'sd1);
    if (pend_vld_q)         proj = proj + (pend_dir_q ? 18'sd1 : -18'sd1);
    nxt       = proj + (drv_dir ? 18'sd1 : -18'sd1);
    lim_block = LIM_EN && ((nxt > 18'(POS_MAX)) || (nxt < 18'(POS_MIN)));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    sm_dir_d   = sm_dir_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    dropped_d  = 1'b0;
    limit_d    = 1'b0;
    srv_vld    = 1'b0;
    srv_dir    = drv_dir;
    tmr_done   = (cnt_q == 16'd0);
    at_serve   = (state_q == IDLE) || ((state_q == PULSE_LO) && tmr_done);
    if (!drv_enable_SM) begin
      state_d    = DISABLED;
      cnt_d      = '0;
      pend_vld_d = 1'b0;
    end else if (state_q == DISABLED) begin
      state_d = WAKE;
      cnt_d   = T_WAKE;
    end else begin
      // A new request is rejected, dropped, served now, or parked in the slot
      if (drv_step) begin
        if (lim_block)       limit_d = 1'b1;
        else if (pend_vld_q) dropped_d = 1'b1;
        else if (at_serve)   srv_vld = 1'b1;
        else begin
          pend_vld_d = 1'b1;
          pend_dir_d = drv_dir;
        end
      end
      if (at_serve && pend_vld_q) begin
        srv_vld    = 1'b1;
        srv_dir    = pend_dir_q;
        pend_vld_d = 1'b0;
      end
      case (state_q)
        WAKE: if (tmr_done) state_d = IDLE; else cnt_d = cnt_q - 16'd1;
        DIR_SET:
          if (tmr_done) begin
            state_d = PULSE_HI;
            cnt_d   = T_HI;
            pos_d   = pos_q + delta(sm_dir_q);
          end else cnt_d = cnt_q - 16'd1;
        PULSE_HI:
          if (tmr_done) begin
            state_d = PULSE_LO;
            cnt_d   = T_LO;
          end else cnt_d = cnt_q - 16'd1;
        PULSE_LO: if (tmr_done) state_d = IDLE; else cnt_d = cnt_q - 16'd1;
        default: ;
      endcase
      if (srv_vld) begin
        if (srv_dir != sm_dir_q) begin
          state_d  = DIR_SET;
          sm_dir_d = srv_dir;
          cnt_d    = T_DIR;
        end else begin
          state_d = PULSE_HI;
          cnt_d   = T_HI;
          pos_d   = pos_q + delta(srv_dir);
        end
      end
    end
    sm_en_d   = (state_d != DISABLED);
    sm_step_d = (state_d == PULSE_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DISABLED;
      cnt_q      <= '0;
      pos_q      <= '0;
      sm_en_q    <= 1'b0;
      sm_step_q  <= 1'b0;
      sm_dir_q   <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_dir_q <= 1'b0;
      dropped_q  <= 1'b0;
      limit_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      sm_en_q    <= sm_en_d;
      sm_step_q  <= sm_step_d;
      sm_dir_q   <= sm_dir_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      dropped_q  <= dropped_d;
      limit_q    <= limit_d;
    end
  end

  assign sm_en        = sm_en_q;
  assign sm_step      = sm_step_q;
  assign sm_dir       = sm_dir_q;
  assign busy         = (state_q != IDLE) && (state_q != DISABLED);
  assign position     = pos_q;
  assign step_dropped = dropped_q;
  assign limit_hit    = limit_q;

endmodule

// File: doc/sm_step_driver.md
SM_STEP_DRIVER -- requirements
Module: sm_step_driver

Interface
REQ-001 Parameter PULSE_W, default 50, sm_step high time in clk cycles (1 us at 50 MHz), legal range 1..1023.
REQ-002 Parameter GAP_W, default 50, minimum sm_step low time after each pulse in clk cycles, legal range 1..1023.
REQ-003 Parameter DIR_SETUP, default 10, cycles sm_dir is held stable before a step edge following a direction change, legal range 1..1023.
REQ-004 Parameter EN_DELAY, default 500, cycles from sm_en rising to the first allowed step, legal range 1..65535.
REQ-005 Parameters POS_MIN, default -16'sd30000, and POS_MAX, default 16'sd30000, soft position limits (used only per REQ-026).
REQ-006 clk  input  1  single system clock, 50 MHz; every register is clocked on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-008 drv_enable_SM  input  1  motor enable request from the tracking controller, level.
REQ-009 drv_step  input  1  step request, one-cycle strobe; each cycle high is one request.
REQ-010 drv_dir  input  1  requested direction for the step in the same cycle: 1 = forward, 0 = reverse.
REQ-011 sm_en  output  1  registered enable to the motor power stage.
REQ-012 sm_step  output  1  registered step pulse to the power stage.
REQ-013 sm_dir  output  1  registered direction to the power stage.
REQ-014 busy  output  1  high in every state except IDLE and DISABLED.
REQ-015 position  output  16  signed step count.
REQ-016 step_dropped  output  1  one-cycle strobe when a request is discarded because the pending slot is full.
REQ-017 limit_hit  output  1  one-cycle strobe when a request is rejected by the soft limit.

Function
REQ-018 The FSM SHALL have states DISABLED, WAKE, IDLE, DIR_SET, PULSE_HI and PULSE_LO.
REQ-019 The FSM SHALL sequence as follows:
- DISABLED to WAKE when drv_enable_SM=1.
- WAKE to IDLE after EN_DELAY cycles.
- IDLE on a request: to DIR_SET if drv_dir differs from sm_dir, otherwise to PULSE_HI.
- DIR_SET to PULSE_HI after DIR_SETUP cycles.
- PULSE_HI to PULSE_LO after PULSE_W cycles.
- PULSE_LO after GAP_W cycles: serve the pending request if one exists, otherwise go to IDLE.
REQ-020 Latency: a request sampled in IDLE with an unchanged direction SHALL give sm_step=1 on the next cycle; with a changed direction, sm_dir SHALL update on the next cycle and sm_step SHALL rise DIR_SETUP cycles later.
REQ-021 sm_step SHALL be high exactly in PULSE_HI; sm_dir SHALL change only on entry to DIR_SET.
REQ-022 Buffering: a single pending slot (request plus direction) SHALL latch a request arriving in WAKE, DIR_SET, PULSE_HI or PULSE_LO.
- A request arriving while the slot is full SHALL be discarded, and step_dropped SHALL pulse once.
REQ-023 Simultaneity: a request arriving in the last PULSE_LO cycle with the slot empty SHALL be served directly, with no extra idle cycle.
REQ-024 Position SHALL update by +1 (sm_dir=1) or -1 (sm_dir=0) on each entry to PULSE_HI, with 16-bit two's-complement wrap (32767 + 1 = -32768).
REQ-025 Disable: drv_enable_SM=0 in any state SHALL, on the next cycle, put the FSM in DISABLED, force sm_en=0 and sm_step=0, and clear the pending slot.
- position SHALL be retained.
- Requests received while in DISABLED SHALL be ignored, with no strobes.

Configuration
REQ-026 With macro SM_POS_LIMIT_EN defined, a request that would move position above POS_MAX or below POS_MIN SHALL NOT be executed or queued, and limit_hit SHALL pulse once.
- Without SM_POS_LIMIT_EN, no limit checking SHALL be performed and limit_hit SHALL be constant 0.
- The port list SHALL be identical in both builds.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set state=DISABLED, sm_en=0, sm_step=0, sm_dir=1, position=0, busy=0, step_dropped=0, limit_hit=0, clear the pending slot, and clear all timers.
REQ-028 rst SHALL take priority over every other input.
- Reset mid-pulse SHALL drop sm_step on the next edge.
- After rst falls, operation SHALL restart from DISABLED, via WAKE if drv_enable_SM=1.

Verification (bench parameters PULSE_W=3, GAP_W=2, DIR_SETUP=2, EN_DELAY=4)
REQ-029 Raise enable at cycle 0, then send a step with dir=1 at cycle 10 -> sm_en=1 from cycle 1; sm_step high in cycles 11-13; position=1; busy clears at cycle 16.
REQ-030 After a forward step, send dir=0 -> sm_dir=0 one cycle later; sm_step rises 2 cycles after that; position returns to 0.
REQ-031 Send 3 strobes in consecutive cycles in IDLE -> 2 pulses with 2-cycle gaps; step_dropped pulses once, on the third strobe.
REQ-032 Drop drv_enable_SM during PULSE_HI while a request is pending -> sm_step=0 and sm_en=0 next cycle; no further pulse after re-enable and WAKE.
REQ-033 Preload position=32767 via 32767 forward steps, then one more step -> without the macro, position=-32768; with SM_POS_LIMIT_EN and POS_MAX=32767, no pulse and limit_hit=1 for one cycle.
REQ-034 Assert rst for 1 cycle at the second cycle of PULSE_HI -> all outputs at their reset values next cycle; position=0.
